// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB master: bus widths, default access timeout
// and the FSM state encoding.
package apb_master_pkg;

    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int TIMEOUT_DEFAULT = 255;
    localparam int CNT_W           = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase timeout counter.
// Ports:
//   PCLK, PRESERN  clock / async active-low reset
//   clear          loads the budget (asserted on the edge that enters SETUP)
//   enable         counts one ACCESS cycle
//   expired        high during the TIMEOUT-th ACCESS cycle
module apb_timeout_counter
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic PCLK,
    input  logic PRESERN,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Loaded with TIMEOUT-1 so the terminal count (zero) coincides with the
    // last permitted ACCESS cycle.
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master bridging a valid/ready command/response
// interface to an APB completer, with an ACCESS-phase timeout.
// Ports:
//   PCLK, PRESERN                        clock / async active-low reset
//   cmd_valid/ready/write/addr/wdata     command from local logic
//   rsp_valid/ready/rdata/err/timeout    response to local logic
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA APB requester outputs (registered)
//   PREADY, PSLVERR, PRDATA              APB completer response
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// SETUP  | one-cycle APB setup phase
// ACCESS | PENABLE high, waiting for PREADY or timeout
// RESP   | response held until rsp_ready
module apb_master
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              PCLK,
    input  logic              PRESERN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [DATA_W-1:0] PRDATA
);

    apb_state_e state_q, state_d;
    logic       accept;
    logic       done_ok;
    logic       done_to;
    logic       expired;

    apb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .PCLK    (PCLK),
        .PRESERN (PRESERN),
        .clear   (accept),
        .enable  (state_q == ST_ACCESS),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done_ok = 1'b0;
        done_to = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                // Completion has priority over a timeout on the same cycle.
                if (PREADY) begin
                    done_ok = 1'b1;
                    state_d = ST_RESP;
                end else if (expired) begin
                    done_to = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control outputs are registered copies decoded from the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q   <= ST_IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            PSEL      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
            PENABLE   <= (state_d == ST_ACCESS);
            cmd_ready <= (state_d == ST_IDLE);
            rsp_valid <= (state_d == ST_RESP);
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                PWRITE <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
            end
            if (done_ok) begin
                rsp_rdata   <= PWRITE ? '0 : PRDATA;
                rsp_err     <= PSLVERR;
                rsp_timeout <= 1'b0;
            end else if (done_to) begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master (TIMEOUT=4): directed scenarios plus
// randomized transfers compared against a transaction-level response model.
module tb_apb_master;
    localparam int TO = 4;

    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;
    logic [31:0] PRDATA = '0;

    int n_checks = 0;
    int n_errors = 0;

    apb_master #(.TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESERN(PRESERN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns the same way.
    // waits = ACCESS cycles with PREADY low before the completer answers.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] prdata, input logic slverr,
                           input int rsp_delay, input logic keep_valid);
        logic [31:0] exp_rdata;
        logic        exp_err, exp_to;
        int          acc;
        if (waits < TO) begin
            acc = waits + 1; exp_to = 1'b0; exp_err = slverr;
            exp_rdata = wr ? 32'h0 : prdata;
        end else begin
            acc = TO; exp_to = 1'b1; exp_err = 1'b1; exp_rdata = 32'h0;
        end

        chk("idle_cmd_ready", cmd_ready, 1'b1);
        chk("idle_psel", PSEL, 1'b0);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        @(posedge PCLK); #1;

        if (keep_valid) begin
            cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
        end else begin
            cmd_valid = 1'b0;
        end
        chk("setup_psel", PSEL, 1'b1);
        chk("setup_penable", PENABLE, 1'b0);
        chk("setup_cmd_ready", cmd_ready, 1'b0);
        chk("setup_rsp_valid", rsp_valid, 1'b0);
        chk("setup_paddr", PADDR, addr);
        chk("setup_pwrite", PWRITE, wr);
        chk("setup_pwdata", PWDATA, wdata);
        PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;

        for (int k = 0; k < acc; k++) begin
            @(posedge PCLK); #1;
            chk("acc_psel", PSEL, 1'b1);
            chk("acc_penable", PENABLE, 1'b1);
            chk("acc_paddr", PADDR, addr);
            chk("acc_pwrite", PWRITE, wr);
            chk("acc_pwdata", PWDATA, wdata);
            chk("acc_rsp_valid", rsp_valid, 1'b0);
            chk("acc_cmd_ready", cmd_ready, 1'b0);
            if (k == waits) begin
                PREADY = 1'b1; PSLVERR = slverr; PRDATA = prdata;
            end else begin
                PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
            end
        end
        @(posedge PCLK); #1;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;

        for (int d = 0; d <= rsp_delay; d++) begin
            chk("resp_psel", PSEL, 1'b0);
            chk("resp_penable", PENABLE, 1'b0);
            chk("resp_valid", rsp_valid, 1'b1);
            chk("resp_rdata", rsp_rdata, exp_rdata);
            chk("resp_err", rsp_err, exp_err);
            chk("resp_timeout", rsp_timeout, exp_to);
            chk("resp_cmd_ready", cmd_ready, 1'b0);
            rsp_ready = (d == rsp_delay);
            if (d == rsp_delay) cmd_valid = 1'b0;
            @(posedge PCLK); #1;
        end
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 1'b0);
        chk("post_cmd_ready", cmd_ready, 1'b1);
        chk("post_psel", PSEL, 1'b0);
    endtask

    task automatic reset_mid_access();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_2000; cmd_wdata = 32'h0;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0; PREADY = 1'b0;
        @(posedge PCLK); #1;
        chk("rst_pre_penable", PENABLE, 1'b1);
        @(negedge PCLK); #2;
        PRESERN = 1'b0;
        #1;
        chk("rst_async_psel", PSEL, 1'b0);
        chk("rst_async_penable", PENABLE, 1'b0);
        chk("rst_async_rsp_valid", rsp_valid, 1'b0);
        chk("rst_async_paddr", PADDR, 32'h0);
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESERN = 1'b1;
        @(posedge PCLK); #1;
        chk("rst_rel_cmd_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            chk("rst_no_rsp", rsp_valid, 1'b0);
            chk("rst_no_psel", PSEL, 1'b0);
            @(posedge PCLK); #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge PCLK);
        #1;
        chk("reset_psel", PSEL, 1'b0);
        chk("reset_penable", PENABLE, 1'b0);
        chk("reset_pwrite", PWRITE, 1'b0);
        chk("reset_paddr", PADDR, 32'h0);
        chk("reset_pwdata", PWDATA, 32'h0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_err", rsp_err, 1'b0);
        chk("reset_rsp_timeout", rsp_timeout, 1'b0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        @(negedge PCLK);
        PRESERN = 1'b1;
        @(posedge PCLK); #1;
        chk("reset_cmd_ready", cmd_ready, 1'b1);

        // write, zero wait; read with 3 waits (completion on the timeout cycle)
        run_txn(1'b1, 32'h0000_1000, 32'h0000_0001, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h0000_1000, 32'h0, 3, 32'h0000_0001, 1'b0, 0, 1'b0);
        // read with slave error; write with slave error
        run_txn(1'b0, 32'h0000_1004, 32'h0, 0, 32'h1234_5678, 1'b1, 0, 1'b0);
        run_txn(1'b1, 32'h0000_1008, 32'hA5A5_A5A5, 1, 32'h1111_1111, 1'b1, 1, 1'b0);
        // timeout: PREADY never answers within TIMEOUT cycles
        run_txn(1'b0, 32'h0000_100C, 32'h0, 10, 32'h2222_2222, 1'b0, 0, 1'b0);
        // stalled response with a command held valid, then immediate follow-up
        run_txn(1'b0, 32'h0000_1010, 32'h0, 2, 32'h3333_3333, 1'b0, 5, 1'b1);
        run_txn(1'b1, 32'h0000_1014, 32'h4444_4444, 0, 32'h0, 1'b0, 0, 1'b0);

        reset_mid_access();

        for (int t = 0; t < 60; t++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom,
                    int'($urandom_range(0, 6)), $urandom, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum ACCESS cycles waiting for PREADY before abort (1..255).
REQ-002 PCLK  in  1  sole clock; all state updates on rising edge.
REQ-003 PRESERN  in  1  reset, asynchronous assert, active-low.
REQ-004 cmd_valid  in  1  command request from local logic.
REQ-005 cmd_ready  out  1  master can accept command (IDLE only).
REQ-006 cmd_write  in  1  1=write, 0=read.
REQ-007 cmd_addr  in  32  target address.
REQ-008 cmd_wdata  in  32  write data.
REQ-009 rsp_valid  out  1  response available.
REQ-010 rsp_ready  in  1  local logic consumes response.
REQ-011 rsp_rdata  out  32  read data; 0 for writes and aborted transfers.
REQ-012 rsp_err  out  1  PSLVERR sampled or timeout.
REQ-013 rsp_timeout  out  1  transfer aborted by timeout.
REQ-014 PSEL, PENABLE, PWRITE  out  1 each  APB control.
REQ-015 PADDR, PWDATA  out  32 each  APB address/write data, registered.
REQ-016 PREADY, PSLVERR  in  1 each; PRDATA  in  32  completer response.

Function
REQ-017 FSM states IDLE, SETUP, ACCESS, RESP; all outputs driven from registers.
REQ-018 IDLE: cmd_ready=1, PSEL=0, PENABLE=0; on cmd_valid&cmd_ready latch write/addr/wdata into PWRITE/PADDR/PWDATA, go SETUP.
REQ-019 SETUP: exactly one cycle, PSEL=1, PENABLE=0; go ACCESS.
REQ-020 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA unchanged from SETUP through transfer end.
REQ-021 ACCESS with PREADY=1: capture PRDATA (reads only) and PSLVERR into rsp regs, go RESP; PSEL/PENABLE low next cycle.
REQ-022 ACCESS cycle counter resets on SETUP entry; when TIMEOUT ACCESS cycles elapse with PREADY=0, go RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-023 PREADY=1 on the same cycle the counter reaches TIMEOUT: completion wins, no timeout.
REQ-024 RESP: rsp_valid=1, outputs stable until rsp_valid&rsp_ready; then IDLE. rsp_valid low in all other states.
REQ-025 cmd_ready=0 in SETUP/ACCESS/RESP; commands presented then are ignored, not queued.
REQ-026 Minimum latency: accept edge N, SETUP cycle N+1, ACCESS N+2 (PREADY=1), rsp_valid cycle N+3; next command accepted no earlier than the cycle after the response handshake.
REQ-027 Writes: rsp_rdata=0; rsp_err reflects PSLVERR.
REQ-028 PSLVERR ignored unless PREADY=1 in ACCESS.

Reset
REQ-029 PRESERN low asynchronously forces IDLE; PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout=0; PADDR, PWDATA, rsp_rdata=0; counter=0; cmd_ready=1 after release.
REQ-030 Reset mid-transfer abandons the transfer; no response is generated for it.

Structure
REQ-031 Package apb_master_pkg holds FSM state encoding, ADDR_W=32, DATA_W=32, default TIMEOUT.
REQ-032 Sub-module apb_timeout_counter (clear, enable, expired) implements REQ-022; FSM and datapath stay in apb_master.

Verification
REQ-033 Write 0x1000/0x00000001, PREADY=1 -> PSEL high 2 cycles, PENABLE 1 cycle, rsp_valid cycle N+3, rsp_err=0, rsp_rdata=0.
REQ-034 Read 0x1000, PREADY low 3 ACCESS cycles, PRDATA=0x00000001 -> ACCESS lasts 4 cycles, PADDR stable, rsp_rdata=0x00000001.
REQ-035 Read with PREADY=1, PSLVERR=1 -> rsp_err=1, rsp_timeout=0.
REQ-036 TIMEOUT=4, PREADY held 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, PSEL=0 next cycle.
REQ-037 PRESERN pulsed low during ACCESS -> PSEL/PENABLE drop immediately, no rsp_valid, cmd_ready=1 after release.
REQ-038 rsp_ready held 0 for 5 cycles with cmd_valid high -> rsp stable, cmd_ready=0, second command accepted only after handshake.
